// File: rtl/axi_rab_pkg.sv
// Shared types for the RAB address stage: FSM states, drop causes and span width.
package axi_rab_pkg;

  localparam int SPAN_W = 33;

  typedef enum logic [1:0] {IDLE, LOOKUP, FWD, DROP} state_e;

  typedef enum logic [2:0] {NONE, MISS, PROT, MULTI, OVF} cause_e;

endpackage

// File: rtl/axi_rab_burst_span.sv
// Last byte address of an AXI burst, computed at 33 bits so a wrap past 4 GiB shows as overflow.
module axi_rab_burst_span
  import axi_rab_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_len,
  input  logic [2:0]  i_size,
  output logic [31:0] o_addr_max,
  output logic        o_overflow
);

  logic [SPAN_W-1:0] w_bytes;
  logic [SPAN_W-1:0] w_end;

  assign w_bytes    = ({{(SPAN_W-8){1'b0}}, i_len} + SPAN_W'(1)) << i_size;
  assign w_end      = {1'b0, i_addr} + w_bytes - SPAN_W'(1);
  assign o_addr_max = w_end[31:0];
  assign o_overflow = w_end[SPAN_W-1];

endmodule

// File: rtl/axi_rab_addr_stage.sv
// Per-port AR/AW stage: accept, slice lookup, then forward or drop. Optional miss log is
// enabled with the AXI_RAB_MISS_LOG_EN macro.
module axi_rab_addr_stage
  import axi_rab_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 6,
  parameter int RAB_ENTRIES    = 16,
  parameter int RW_TYPE        = 0
)(
  input  logic                      axi4_aclk,
  input  logic                      axi4_arstn,
  input  logic [31:0]               s_addr,
  input  logic [AXI_ID_WIDTH-1:0]   s_id,
  input  logic [7:0]                s_len,
  input  logic [2:0]                s_size,
  input  logic [AXI_USER_WIDTH-1:0] s_user,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [31:0]               int_addr_min,
  output logic [31:0]               int_addr_max,
  output logic                      int_rw,
  input  logic [RAB_ENTRIES-1:0]    hit,
  input  logic [RAB_ENTRIES-1:0]    prot,
  input  logic                      multiple_hit,
  input  logic [31:0]               out_addr,
  output logic [31:0]               m_addr,
  output logic [AXI_ID_WIDTH-1:0]   m_id,
  output logic [7:0]                m_len,
  output logic [2:0]                m_size,
  output logic [AXI_USER_WIDTH-1:0] m_user,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [AXI_ID_WIDTH-1:0]   drop_id,
  output logic [7:0]                drop_len,
  output logic                      drop_valid,
  input  logic                      drop_ready,
  output logic                      miss_irq,
  output logic                      prot_irq,
  output logic                      multi_irq,
  output logic [31:0]               miss_addr,
  output logic [AXI_ID_WIDTH-1:0]   miss_id,
  output logic                      miss_valid,
  input  logic                      miss_clr
);

  state_e                    r_state;
  logic                      r_s_ready;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [7:0]                r_len;
  logic [2:0]                r_size;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic [31:0]               r_int_min;
  logic [31:0]               r_int_max;
  logic                      r_ovf;
  logic [31:0]               r_m_addr;
  logic                      r_m_valid;
  logic                      r_drop_valid;
  logic                      r_miss_irq;
  logic                      r_prot_irq;
  logic                      r_multi_irq;
  logic [31:0]               w_addr_max;
  logic                      w_ovf;
  cause_e                    w_cause;

  // Span is computed from the incoming request so it is already registered during LOOKUP.
  axi_rab_burst_span u_span (
    .i_addr     (s_addr),
    .i_len      (s_len),
    .i_size     (s_size),
    .o_addr_max (w_addr_max),
    .o_overflow (w_ovf)
  );

  always_comb begin
    w_cause = NONE;
    if (r_ovf)                 w_cause = OVF;
    else if (multiple_hit)     w_cause = MULTI;
    else if (~|hit)            w_cause = MISS;
    else if (|(hit & prot))    w_cause = PROT;
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      r_state      <= IDLE;
      r_s_ready    <= 1'b0;
      r_id         <= '0;
      r_len        <= '0;
      r_size       <= '0;
      r_user       <= '0;
      r_int_min    <= '0;
      r_int_max    <= '0;
      r_ovf        <= 1'b0;
      r_m_addr     <= '0;
      r_m_valid    <= 1'b0;
      r_drop_valid <= 1'b0;
      r_miss_irq   <= 1'b0;
      r_prot_irq   <= 1'b0;
      r_multi_irq  <= 1'b0;
    end else begin
      r_miss_irq  <= 1'b0;
      r_prot_irq  <= 1'b0;
      r_multi_irq <= 1'b0;
      case (r_state)
        IDLE: begin
          r_s_ready <= 1'b1;
          if (s_valid && r_s_ready) begin
            r_s_ready <= 1'b0;
            r_id      <= s_id;
            r_len     <= s_len;
            r_size    <= s_size;
            r_user    <= s_user;
            r_int_min <= s_addr;
            r_int_max <= w_addr_max;
            r_ovf     <= w_ovf;
            r_state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_cause == NONE) begin
            r_m_addr  <= out_addr;
            r_m_valid <= 1'b1;
            r_state   <= FWD;
          end else begin
            r_drop_valid <= 1'b1;
            r_miss_irq   <= (w_cause == MISS) || (w_cause == OVF);
            r_prot_irq   <= (w_cause == PROT);
            r_multi_irq  <= (w_cause == MULTI);
            r_state      <= DROP;
          end
        end
        FWD: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        DROP: begin
          if (drop_ready) begin
            r_drop_valid <= 1'b0;
            r_s_ready    <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready      = r_s_ready;
  assign int_addr_min = r_int_min;
  assign int_addr_max = r_int_max;
  assign int_rw       = (RW_TYPE != 0);
  assign m_addr       = r_m_addr;
  assign m_id         = r_id;
  assign m_len        = r_len;
  assign m_size       = r_size;
  assign m_user       = r_user;
  assign m_valid      = r_m_valid;
  assign drop_id      = r_id;
  assign drop_len     = r_len;
  assign drop_valid   = r_drop_valid;
  assign miss_irq     = r_miss_irq;
  assign prot_irq     = r_prot_irq;
  assign multi_irq    = r_multi_irq;

`ifdef AXI_RAB_MISS_LOG_EN
  logic                    r_miss_valid;
  logic [31:0]             r_miss_addr;
  logic [AXI_ID_WIDTH-1:0] r_miss_id;

  // First miss is kept until cleared; a capture takes priority over a same-cycle clear.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      r_miss_valid <= 1'b0;
      r_miss_addr  <= '0;
      r_miss_id    <= '0;
    end else if ((r_state == LOOKUP) && ((w_cause == MISS) || (w_cause == OVF)) && !r_miss_valid) begin
      r_miss_valid <= 1'b1;
      r_miss_addr  <= r_int_min;
      r_miss_id    <= r_id;
    end else if (miss_clr) begin
      r_miss_valid <= 1'b0;
    end
  end

  assign miss_valid = r_miss_valid;
  assign miss_addr  = r_miss_addr;
  assign miss_id    = r_miss_id;
`else
  logic w_unused_miss_clr;
  assign w_unused_miss_clr = miss_clr;
  assign miss_valid = 1'b0;
  assign miss_addr  = '0;
  assign miss_id    = '0;
`endif

endmodule

// File: tb/tb_axi_rab_addr_stage.sv
// Scoreboard bench for axi_rab_addr_stage: one line per request, expectations from a small model.
module tb_axi_rab_addr_stage;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] s_addr = '0;
  logic [3:0]  s_id = '0;
  logic [7:0]  s_len = '0;
  logic [2:0]  s_size = '0;
  logic [5:0]  s_user = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] int_addr_min, int_addr_max;
  logic        int_rw;
  logic [15:0] hit = '0, prot = '0;
  logic        multiple_hit = 1'b0;
  logic [31:0] out_addr = '0;
  logic [31:0] m_addr;
  logic [3:0]  m_id;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  logic [5:0]  m_user;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [3:0]  drop_id;
  logic [7:0]  drop_len;
  logic        drop_valid;
  logic        drop_ready = 1'b0;
  logic        miss_irq, prot_irq, multi_irq;
  logic [31:0] miss_addr;
  logic [3:0]  miss_id;
  logic        miss_valid;
  logic        miss_clr = 1'b0;

  axi_rab_addr_stage dut (
    .axi4_aclk(clk), .axi4_arstn(rstn),
    .s_addr(s_addr), .s_id(s_id), .s_len(s_len), .s_size(s_size), .s_user(s_user),
    .s_valid(s_valid), .s_ready(s_ready),
    .int_addr_min(int_addr_min), .int_addr_max(int_addr_max), .int_rw(int_rw),
    .hit(hit), .prot(prot), .multiple_hit(multiple_hit), .out_addr(out_addr),
    .m_addr(m_addr), .m_id(m_id), .m_len(m_len), .m_size(m_size), .m_user(m_user),
    .m_valid(m_valid), .m_ready(m_ready),
    .drop_id(drop_id), .drop_len(drop_len), .drop_valid(drop_valid), .drop_ready(drop_ready),
    .miss_irq(miss_irq), .prot_irq(prot_irq), .multi_irq(multi_irq),
    .miss_addr(miss_addr), .miss_id(miss_id), .miss_valid(miss_valid), .miss_clr(miss_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        drop;
    logic [31:0] m_addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [5:0]  user;
    logic [31:0] amax;
    logic        mirq, pirq, uirq;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

`ifdef AXI_RAB_MISS_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif
  logic        exp_log_v = 1'b0;
  logic [31:0] exp_log_addr = '0;
  logic [3:0]  exp_log_id = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_log();
    check_eq("miss_valid", miss_valid, exp_log_v);
    check_eq("miss_addr", miss_addr, exp_log_addr);
    check_eq("miss_id", miss_id, exp_log_id);
  endtask

  task automatic check_all_zero(input string where);
    check_eq({where, "_s_ready"}, s_ready, 0);
    check_eq({where, "_m_valid"}, m_valid, 0);
    check_eq({where, "_m_addr"}, m_addr, 0);
    check_eq({where, "_m_id"}, m_id, 0);
    check_eq({where, "_drop_valid"}, drop_valid, 0);
    check_eq({where, "_int_addr_max"}, int_addr_max, 0);
    check_eq({where, "_irqs"}, {miss_irq, prot_irq, multi_irq}, 0);
    check_eq({where, "_miss_valid"}, miss_valid, 0);
    check_eq({where, "_int_rw"}, int_rw, 0);
  endtask

  task automatic check_payload(input exp_t e, input logic irq_exp);
    check_eq("m_valid", m_valid, !e.drop);
    check_eq("drop_valid", drop_valid, e.drop);
    check_eq("s_ready_busy", s_ready, 0);
    check_eq("int_addr_max_hold", int_addr_max, e.amax);
    if (!e.drop) begin
      check_eq("m_addr", m_addr, e.m_addr);
      check_eq("m_id", m_id, e.id);
      check_eq("m_len", m_len, e.len);
      check_eq("m_size", m_size, e.size);
      check_eq("m_user", m_user, e.user);
    end else begin
      check_eq("drop_id", drop_id, e.id);
      check_eq("drop_len", drop_len, e.len);
    end
    check_eq("miss_irq", miss_irq, irq_exp & e.mirq);
    check_eq("prot_irq", prot_irq, irq_exp & e.pirq);
    check_eq("multi_irq", multi_irq, irq_exp & e.uirq);
  endtask

  // Drive one request; abort=1 resets the DUT while the output is pending.
  task automatic run_req(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [5:0] user, input logic [15:0] h,
                         input logic [15:0] p, input logic mh, input logic [31:0] oaddr,
                         input int hold, input bit abort);
    exp_t e;
    logic [63:0] span_end;
    logic ovf;
    int wait_cnt;
    span_end = {32'd0, addr} + (({56'd0, len} + 64'd1) << size) - 64'd1;
    ovf = (span_end > 64'hFFFF_FFFF);
    e.amax = span_end[31:0];
    e.id = id; e.len = len; e.size = size; e.user = user; e.m_addr = oaddr;
    e.mirq = 0; e.pirq = 0; e.uirq = 0; e.drop = 1;
    if (ovf)                 e.mirq = 1;
    else if (mh)             e.uirq = 1;
    else if (h == 16'd0)     e.mirq = 1;
    else if ((h & p) != 0)   e.pirq = 1;
    else                     e.drop = 0;
    sb.push_back(e);
    if (LOG_EN && e.mirq && !exp_log_v) begin
      exp_log_v = 1; exp_log_addr = addr; exp_log_id = id;
    end

    hit = h; prot = p; multiple_hit = mh; out_addr = oaddr;
    wait_cnt = 0;
    @(negedge clk);
    while (!s_ready && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    check_eq("s_ready_idle", s_ready, 1);
    s_addr = addr; s_id = id; s_len = len; s_size = size; s_user = user; s_valid = 1;
    @(posedge clk);
    #1 s_valid = 0;
    @(negedge clk);
    check_eq("lookup_s_ready", s_ready, 0);
    check_eq("int_addr_min", int_addr_min, addr);
    check_eq("int_addr_max", int_addr_max, e.amax);
    check_eq("lookup_valids", {m_valid, drop_valid}, 0);

    wait_cnt = 0;
    do begin
      @(negedge clk);
      wait_cnt++;
    end while (!(m_valid || drop_valid) && wait_cnt < 8);
    check_eq("out_latency", wait_cnt, 1);
    e = sb.pop_front();
    check_payload(e, 1'b1);
    check_log();
    $display("req addr=0x%08h id=%0d len=%0d size=%0d -> %s m_addr=0x%08h irq(m/p/u)=%0d%0d%0d",
             addr, id, len, size, e.drop ? "drop" : "fwd", m_addr, miss_irq, prot_irq, multi_irq);

    if (abort) begin
      rstn = 0;
      #1;
      check_all_zero("async_rst");
      exp_log_v = 0; exp_log_addr = '0; exp_log_id = '0;
      @(posedge clk);
      #1 rstn = 1;
      return;
    end

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_payload(e, 1'b0);
    end
    if (e.drop) drop_ready = 1; else m_ready = 1;
    @(posedge clk);
    #1 begin drop_ready = 0; m_ready = 0; end
    @(negedge clk);
    check_eq("done_valids", {m_valid, drop_valid}, 0);
    check_eq("done_s_ready", s_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rstn = 1;
    repeat (2) @(negedge clk);
    check_eq("post_reset_s_ready", s_ready, 1);

    // Readies while nothing is pending must not disturb the idle stage.
    m_ready = 1; drop_ready = 1;
    repeat (3) @(negedge clk);
    check_eq("idle_ready_ignored", {m_valid, drop_valid, s_ready}, 3'b001);
    m_ready = 0; drop_ready = 0;

    run_req(32'h1000_0000, 4'd5, 8'd3, 3'd2, 6'h2A, 16'h0008, 16'h0000, 0, 32'h8000_0100, 10, 0);
    run_req(32'h2000_0040, 4'd9, 8'd1, 3'd3, 6'h01, 16'h0000, 16'h0000, 0, 32'h0, 2, 0);
    run_req(32'h3000_0000, 4'd2, 8'd0, 3'd0, 6'h02, 16'h0000, 16'h0000, 0, 32'h0, 1, 0);

    @(negedge clk) miss_clr = 1;
    @(posedge clk);
    #1 miss_clr = 0;
    exp_log_v = 0;
    @(negedge clk);
    check_eq("miss_clr", miss_valid, exp_log_v);

    run_req(32'h5000_0000, 4'd7, 8'd15, 3'd2, 6'h10, 16'h0020, 16'h0020, 0, 32'h0, 3, 0);
    run_req(32'h5000_1000, 4'd6, 8'd15, 3'd2, 6'h11, 16'h0002, 16'h0020, 0, 32'hA000_1000, 1, 0);
    run_req(32'h6000_0000, 4'd3, 8'd0, 3'd1, 6'h12, 16'h0003, 16'h0000, 1, 32'h0, 1, 0);
    run_req(32'hFFFF_FFF0, 4'd4, 8'd7, 3'd2, 6'h13, 16'h0001, 16'h0000, 0, 32'h0, 2, 0);
    run_req(32'hFFFF_FFE0, 4'd8, 8'd7, 3'd2, 6'h14, 16'h0001, 16'h0000, 0, 32'h1234_0000, 1, 0);
    run_req(32'h4000_0000, 4'd1, 8'd255, 3'd7, 6'h15, 16'h8000, 16'h0000, 0, 32'h0BAD_0000, 1, 0);

    run_req(32'h7000_0000, 4'd10, 8'd2, 3'd2, 6'h16, 16'h0010, 16'h0000, 0, 32'hC000_0000, 1, 1);
    repeat (2) @(negedge clk);
    check_eq("after_abort_idle", {m_valid, drop_valid, miss_irq}, 0);
    run_req(32'h7100_0000, 4'd11, 8'd1, 3'd0, 6'h17, 16'h0100, 16'h0000, 0, 32'hC100_0000, 1, 0);

    for (int k = 0; k < 6; k++) begin
      run_req($urandom, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
              6'($urandom_range(0, 63)), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom),
              16'($urandom_range(0, 1) == 0 ? 0 : $urandom), ($urandom_range(0, 4) == 0),
              $urandom, $urandom_range(1, 3), 0);
    end

    check_eq("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
